// File: rtl/main_mem_arbiter.sv
// Two-port arbiter sharing one main-memory port between the cache controller (port 0)
// and the page-table walker (port 1); one transaction at a time, guarded by a watchdog.
module main_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int WORD_W      = 32,
    parameter int BLOCK_W     = 512,
    parameter int FIXED_PRIO  = 0,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  p0_addr,
    input  logic [WORD_W-1:0]  p0_wdata,
    input  logic               p0_rd_req,
    input  logic               p0_wr_req,
    output logic [BLOCK_W-1:0] p0_rdata,
    output logic               p0_ready,
    output logic               p0_err,
    input  logic [ADDR_W-1:0]  p1_addr,
    input  logic [WORD_W-1:0]  p1_wdata,
    input  logic               p1_rd_req,
    input  logic               p1_wr_req,
    output logic [BLOCK_W-1:0] p1_rdata,
    output logic               p1_ready,
    output logic               p1_err,
    output logic [ADDR_W-1:0]  main_mem_addr,
    output logic [WORD_W-1:0]  main_mem_data_out,
    output logic               main_mem_read_req,
    output logic               main_mem_write_req,
    input  logic [BLOCK_W-1:0] main_mem_data_in,
    input  logic               main_mem_ready,
    output logic               arb_busy,
    output logic               arb_grant
);

    localparam int WD_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state, state_nxt;
    logic               op_wr, op_wr_nxt;
    logic               rr, rr_nxt;
    logic [WD_W-1:0]    wd, wd_nxt;
    logic               grant_nxt;
    logic               busy_nxt;
    logic               rd_strobe_nxt, wr_strobe_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [WORD_W-1:0]  data_nxt;
    logic [BLOCK_W-1:0] p0_rdata_nxt, p1_rdata_nxt;
    logic               p0_ready_nxt, p1_ready_nxt;
    logic               p0_err_nxt, p1_err_nxt;
    logic               req0, req1, winner;
    logic [BLOCK_W-1:0] block;

    assign req0 = p0_rd_req | p0_wr_req;
    assign req1 = p1_rd_req | p1_wr_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            op_wr              <= 1'b0;
            rr                 <= 1'b0;
            wd                 <= '0;
            arb_grant          <= 1'b0;
            arb_busy           <= 1'b0;
            main_mem_read_req  <= 1'b0;
            main_mem_write_req <= 1'b0;
            main_mem_addr      <= '0;
            main_mem_data_out  <= '0;
            p0_rdata           <= '0;
            p1_rdata           <= '0;
            p0_ready           <= 1'b0;
            p1_ready           <= 1'b0;
            p0_err             <= 1'b0;
            p1_err             <= 1'b0;
        end else begin
            state              <= state_nxt;
            op_wr              <= op_wr_nxt;
            rr                 <= rr_nxt;
            wd                 <= wd_nxt;
            arb_grant          <= grant_nxt;
            arb_busy           <= busy_nxt;
            main_mem_read_req  <= rd_strobe_nxt;
            main_mem_write_req <= wr_strobe_nxt;
            main_mem_addr      <= addr_nxt;
            main_mem_data_out  <= data_nxt;
            p0_rdata           <= p0_rdata_nxt;
            p1_rdata           <= p1_rdata_nxt;
            p0_ready           <= p0_ready_nxt;
            p1_ready           <= p1_ready_nxt;
            p0_err             <= p0_err_nxt;
            p1_err             <= p1_err_nxt;
        end
    end

    // Every output is computed one cycle ahead so that it is registered in the state it belongs to.
    always_comb begin
        state_nxt     = state;
        op_wr_nxt     = op_wr;
        rr_nxt        = rr;
        wd_nxt        = wd;
        grant_nxt     = arb_grant;
        rd_strobe_nxt = 1'b0;
        wr_strobe_nxt = 1'b0;
        addr_nxt      = main_mem_addr;
        data_nxt      = main_mem_data_out;
        p0_rdata_nxt  = p0_rdata;
        p1_rdata_nxt  = p1_rdata;
        p0_ready_nxt  = 1'b0;
        p1_ready_nxt  = 1'b0;
        p0_err_nxt    = 1'b0;
        p1_err_nxt    = 1'b0;
        winner        = 1'b0;
        block         = '0;

        case (state)
            S_IDLE: begin
                if (req0 && req1) begin
                    winner = (FIXED_PRIO != 0) ? 1'b0 : rr;
                end else begin
                    winner = req1;
                end
                if (req0 || req1) begin
                    grant_nxt = winner;
                    if (winner) begin
                        op_wr_nxt = p1_wr_req;
                        addr_nxt  = p1_addr;
                        data_nxt  = p1_wdata;
                    end else begin
                        op_wr_nxt = p0_wr_req;
                        addr_nxt  = p0_addr;
                        data_nxt  = p0_wdata;
                    end
                    wr_strobe_nxt = op_wr_nxt;
                    rd_strobe_nxt = !op_wr_nxt;
                    state_nxt     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_nxt    = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (main_mem_ready) begin
                    block = op_wr ? '0 : main_mem_data_in;
                    if (arb_grant) begin
                        p1_rdata_nxt = block;
                        p1_ready_nxt = 1'b1;
                    end else begin
                        p0_rdata_nxt = block;
                        p0_ready_nxt = 1'b1;
                    end
                    state_nxt = S_RESP;
                end else if (TIMEOUT_CYC != 0 && wd == WD_LAST) begin
                    if (arb_grant) begin
                        p1_rdata_nxt = '0;
                        p1_ready_nxt = 1'b1;
                        p1_err_nxt   = 1'b1;
                    end else begin
                        p0_rdata_nxt = '0;
                        p0_ready_nxt = 1'b1;
                        p0_err_nxt   = 1'b1;
                    end
                    state_nxt = S_RESP;
                end else begin
                    wd_nxt = wd + 1'b1;
                end
            end
            S_RESP: begin
                rr_nxt    = ~arb_grant;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed self-checking bench for main_mem_arbiter; a second instance with FIXED_PRIO=1
// shares the stimulus so its grant sequence can be compared on the same traffic.
module tb_main_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 512;

    logic               clk;
    logic               rst_n;
    logic [ADDR_W-1:0]  p0_addr, p1_addr;
    logic [WORD_W-1:0]  p0_wdata, p1_wdata;
    logic               p0_rd_req, p0_wr_req, p1_rd_req, p1_wr_req;
    logic [BLOCK_W-1:0] main_mem_data_in;
    logic               main_mem_ready;

    logic [BLOCK_W-1:0] p0_rdata, p1_rdata;
    logic               p0_ready, p1_ready, p0_err, p1_err;
    logic [ADDR_W-1:0]  main_mem_addr;
    logic [WORD_W-1:0]  main_mem_data_out;
    logic               main_mem_read_req, main_mem_write_req;
    logic               arb_busy, arb_grant;

    logic [BLOCK_W-1:0] fp_p0_rdata, fp_p1_rdata;
    logic               fp_p0_ready, fp_p1_ready, fp_p0_err, fp_p1_err;
    logic [ADDR_W-1:0]  fp_addr;
    logic [WORD_W-1:0]  fp_data_out;
    logic               fp_read_req, fp_write_req;
    logic               fp_busy, fp_grant;

    int   cmp_count  = 0;
    int   fail_count = 0;
    logic fp_grant_seen;

    main_mem_arbiter #(
        .ADDR_W(ADDR_W), .WORD_W(WORD_W), .BLOCK_W(BLOCK_W), .FIXED_PRIO(0), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rd_req(p0_rd_req), .p0_wr_req(p0_wr_req),
        .p0_rdata(p0_rdata), .p0_ready(p0_ready), .p0_err(p0_err),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rd_req(p1_rd_req), .p1_wr_req(p1_wr_req),
        .p1_rdata(p1_rdata), .p1_ready(p1_ready), .p1_err(p1_err),
        .main_mem_addr(main_mem_addr), .main_mem_data_out(main_mem_data_out),
        .main_mem_read_req(main_mem_read_req), .main_mem_write_req(main_mem_write_req),
        .main_mem_data_in(main_mem_data_in), .main_mem_ready(main_mem_ready),
        .arb_busy(arb_busy), .arb_grant(arb_grant)
    );

    main_mem_arbiter #(
        .ADDR_W(ADDR_W), .WORD_W(WORD_W), .BLOCK_W(BLOCK_W), .FIXED_PRIO(1), .TIMEOUT_CYC(8)
    ) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rd_req(p0_rd_req), .p0_wr_req(p0_wr_req),
        .p0_rdata(fp_p0_rdata), .p0_ready(fp_p0_ready), .p0_err(fp_p0_err),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rd_req(p1_rd_req), .p1_wr_req(p1_wr_req),
        .p1_rdata(fp_p1_rdata), .p1_ready(fp_p1_ready), .p1_err(fp_p1_err),
        .main_mem_addr(fp_addr), .main_mem_data_out(fp_data_out),
        .main_mem_read_req(fp_read_req), .main_mem_write_req(fp_write_req),
        .main_mem_data_in(main_mem_data_in), .main_mem_ready(main_mem_ready),
        .arb_busy(fp_busy), .arb_grant(fp_grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got running expected finished");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [BLOCK_W-1:0] got,
                               input logic [BLOCK_W-1:0] exp);
        cmp_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BLOCK_W-1:0] mkBlock(input logic [31:0] n);
        return {16{n}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit port, input bit rd, input bit wr,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            p1_rd_req = rd; p1_wr_req = wr; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_rd_req = rd; p0_wr_req = wr; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        main_mem_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Called in an IDLE cycle with requests already driven; returns in the following IDLE cycle.
    // drop: 0 keep requests, 1 drop the served port, 2 drop both ports.
    task automatic serve(input string tag, input bit port, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [BLOCK_W-1:0] blk, input int lat, input int drop);
        tick();
        fp_grant_seen = fp_grant;
        checkOutput({tag, "_grant"}, arb_grant, port);
        checkOutput({tag, "_rd_strobe"}, main_mem_read_req, !wr);
        checkOutput({tag, "_wr_strobe"}, main_mem_write_req, wr);
        checkOutput({tag, "_addr"}, main_mem_addr, addr);
        if (wr) checkOutput({tag, "_data_out"}, main_mem_data_out, wdata);
        tick();
        checkOutput({tag, "_strobe_one_cycle"}, main_mem_read_req | main_mem_write_req, 1'b0);
        repeat (lat - 1) tick();
        main_mem_ready   = 1'b1;
        main_mem_data_in = blk;
        tick();
        main_mem_ready   = 1'b0;
        main_mem_data_in = {16{32'hDEAD_BEEF}};
        checkOutput({tag, "_ready"}, port ? p1_ready : p0_ready, 1'b1);
        checkOutput({tag, "_other_ready"}, port ? p0_ready : p1_ready, 1'b0);
        checkOutput({tag, "_err"}, p0_err | p1_err, 1'b0);
        checkOutput({tag, "_rdata"}, port ? p1_rdata : p0_rdata, wr ? '0 : blk);
        if (drop == 1) applyStimulus(port, 1'b0, 1'b0, 32'h0, 32'h0);
        if (drop == 2) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        tick();
        checkOutput({tag, "_ready_pulse"}, p0_ready | p1_ready, 1'b0);
        checkOutput({tag, "_idle"}, arb_busy, 1'b0);
    endtask

    initial begin
        rst_n            = 1'b0;
        main_mem_ready   = 1'b0;
        main_mem_data_in = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        $display("[TB] reset state and single read");
        tick();
        tick();
        checkOutput("rst_busy", arb_busy, 1'b0);
        checkOutput("rst_grant", arb_grant, 1'b0);
        checkOutput("rst_strobes", {main_mem_read_req, main_mem_write_req}, 2'b00);
        checkOutput("rst_addr", main_mem_addr, 32'h0);
        checkOutput("rst_ready", {p0_ready, p1_ready, p0_err, p1_err}, 4'b0);
        checkOutput("rst_rdata", p0_rdata, '0);
        rst_n = 1'b1;
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0);
        serve("t1", 1'b0, 1'b0, 32'h1000, 32'h0, mkBlock(64), 3, 1);
        checkOutput("t1_rdata_hold", p0_rdata, mkBlock(64));

        $display("[TB] simultaneous requests after reset");
        resetDut();
        checkOutput("t2_rdata_reset", p0_rdata, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h41000, 32'h0);
        serve("t2a", 1'b0, 1'b0, 32'h1000, 32'h0, mkBlock(1000), 2, 1);
        serve("t2b", 1'b1, 1'b0, 32'h41000, 32'h0, mkBlock(4100), 1, 1);

        $display("[TB] both ports held for four transactions");
        resetDut();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h41000, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (i[0] == 1'b0) serve("t3_rr", 1'b0, 1'b0, 32'h1000, 32'h0, mkBlock(32'h10 + i), 1, (i == 3) ? 2 : 0);
            else              serve("t3_rr", 1'b1, 1'b0, 32'h41000, 32'h0, mkBlock(32'h10 + i), 1, (i == 3) ? 2 : 0);
            checkOutput("t3_fixed_grant", fp_grant_seen, 1'b0);
        end

        $display("[TB] stray memory ready and writes");
        main_mem_ready   = 1'b1;
        main_mem_data_in = mkBlock(99);
        tick();
        main_mem_ready = 1'b0;
        tick();
        checkOutput("t4_stray_busy", arb_busy, 1'b0);
        checkOutput("t4_stray_ready", {p0_ready, p1_ready}, 2'b00);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h2000, 32'hCAFEBABE);
        serve("t4_p1wr", 1'b1, 1'b1, 32'h2000, 32'hCAFEBABE, mkBlock(55), 2, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h3000, 32'h12345678);
        serve("t4_p0rdwr", 1'b0, 1'b1, 32'h3000, 32'h12345678, mkBlock(56), 1, 1);

        $display("[TB] watchdog timeout");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h4000, 32'h0);
        serve("t5_pre", 1'b0, 1'b0, 32'h4000, 32'h0, mkBlock(32'h77), 1, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h5000, 32'h0);
        tick();
        checkOutput("t5_strobe", main_mem_read_req, 1'b1);
        tick();
        for (int i = 1; i < 8; i++) begin
            tick();
            checkOutput($sformatf("t5_early_%0d", i), p0_ready, 1'b0);
        end
        tick();
        checkOutput("t5_ready", p0_ready, 1'b1);
        checkOutput("t5_err", p0_err, 1'b1);
        checkOutput("t5_rdata", p0_rdata, '0);
        checkOutput("t5_p1_quiet", {p1_ready, p1_err}, 2'b00);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("t5_err_pulse", {p0_ready, p0_err}, 2'b00);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h6000, 32'h0);
        serve("t5_next", 1'b1, 1'b0, 32'h6000, 32'h0, mkBlock(32'h66), 2, 1);

        $display("[TB] reset during WAIT");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h7000, 32'h0);
        tick();
        tick();
        tick();
        checkOutput("t6_busy_before", arb_busy, 1'b1);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        checkOutput("t6_busy", arb_busy, 1'b0);
        checkOutput("t6_addr", main_mem_addr, 32'h0);
        checkOutput("t6_p1_rdata", p1_rdata, '0);
        tick();
        rst_n            = 1'b1;
        main_mem_ready   = 1'b1;
        main_mem_data_in = mkBlock(32'h88);
        tick();
        main_mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("t6_no_ready", {p0_ready, p1_ready, p0_err, p1_err}, 4'b0);
            checkOutput("t6_idle", arb_busy, 1'b0);
            checkOutput("t6_p0_rdata", p0_rdata, '0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
